// File: rtl/multicore_sched_pkg.sv
// Shared sizing constants and boot-sequencer state type for the rede_float
// core-array scheduler.
package multicore_sched_pkg;
  localparam int N_CORES = 31;
  localparam int DATA_W = 28;
  localparam int EN_W = 4;
  localparam logic [EN_W-1:0] OUT_CODE = EN_W'(1);
  localparam int STAGGER = 12;
  localparam int TAG_W = $clog2(N_CORES);
  localparam int CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  typedef enum logic {BOOT, DONE} boot_state_e;
endpackage

// File: rtl/multicore_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last grant and
// remembers the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [IW-1:0] last_grant;
  logic [IW-1:0] cand;
  logic          found;

  assign any = |req;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((32'(last_grant) + 32'(k)) % 32'(N));
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (advance && found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant <= IW'(N - 1);
    else if (advance && found) last_grant <= gnt_idx;
  end
endmodule

// File: rtl/multicore_sched.sv
// Staggered reset release for the core array, per-core result capture and a
// single round-robin valid/ready output stream tagged with the core index.
module multicore_sched
  import multicore_sched_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CORES*DATA_W-1:0]   core_data,
  input  logic [N_CORES*EN_W-1:0]     core_en,
  output logic [N_CORES-1:0]          core_rst,
  output logic                        boot_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_W-1:0]    out_data,
  output logic [TAG_W-1:0]            out_tag,
  output logic [N_CORES-1:0]          overrun
);
  boot_state_e       state;
  logic [TAG_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;

  logic [N_CORES-1:0]       evt_p0;
  logic [N_CORES-1:0]       pending_p0;
  logic signed [DATA_W-1:0] cap_data_p0 [N_CORES];
  logic [N_CORES-1:0]       gnt;
  logic [TAG_W-1:0]         gnt_idx;
  logic                     any;
  logic                     free;

  // Boot sequencer: a core is released whenever cnt sits at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      idx       <= '0;
      cnt       <= '0;
      core_rst  <= '1;
      boot_done <= 1'b0;
    end else if (state == BOOT) begin
      if (cnt == '0) begin
        core_rst[idx] <= 1'b0;
        if (idx == TAG_W'(N_CORES - 1)) begin
          state     <= DONE;
          boot_done <= 1'b1;
        end
      end
      if (cnt == CNT_W'(STAGGER - 1)) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Stage p0: rising-edge detect on the result code and capture
  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    logic                     hit;
    logic                     hit_d;
    logic                     pend;
    logic                     ovr;
    logic signed [DATA_W-1:0] dat;

    assign hit            = (core_en[i*EN_W +: EN_W] == OUT_CODE);
    assign evt_p0[i]      = hit && !hit_d && !core_rst[i];
    assign pending_p0[i]  = pend;
    assign overrun[i]     = ovr;
    assign cap_data_p0[i] = dat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hit_d <= 1'b0;
        pend  <= 1'b0;
        ovr   <= 1'b0;
      end else begin
        hit_d <= hit;
        if (evt_p0[i]) pend <= 1'b1;
        else if (gnt[i]) pend <= 1'b0;
        if (evt_p0[i] && pend && !gnt[i]) ovr <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (evt_p0[i]) dat <= signed'(core_data[i*DATA_W +: DATA_W]);
    end
  end

  assign free = !out_valid || out_ready;

  rr_arbiter #(.N(N_CORES), .IW(TAG_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pending_p0),
    .advance (free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Stage p1: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (free) begin
      out_valid <= any;
      if (any) begin
        out_data <= cap_data_p0[gnt_idx];
        out_tag  <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_multicore_sched.sv
// Directed bench for multicore_sched: boot timing, capture, round-robin order,
// back-pressure with overrun, reset masking and mid-stream reset.
module tb_multicore_sched;
  import multicore_sched_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic [N_CORES*DATA_W-1:0] core_data;
  logic [N_CORES*EN_W-1:0]   core_en;
  logic [N_CORES-1:0]        core_rst;
  logic                      boot_done;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DATA_W-1:0]  out_data;
  logic [TAG_W-1:0]          out_tag;
  logic [N_CORES-1:0]        overrun;

  int errors;
  int checks;

  multicore_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_data (core_data),
    .core_en   (core_en),
    .core_rst  (core_rst),
    .boot_done (boot_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic [EN_W-1:0] en, input int d);
    core_en[i*EN_W +: EN_W]     = en;
    core_data[i*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  // 1 = core still held in reset after edge e (core k falls at edge 1 + 12k)
  function automatic logic [N_CORES-1:0] boot_mask(input int e);
    logic [N_CORES-1:0] m;
    for (int k = 0; k < N_CORES; k++) m[k] = (e < 1 + k * 12);
    return m;
  endfunction

  task automatic test_reset();
    checks++;
    if (core_rst !== '1) begin errors++; $display("FAIL reset_core_rst got %h exp all ones", core_rst); end
    checks++;
    if (boot_done !== 1'b0) begin errors++; $display("FAIL reset_boot_done got %b exp 0", boot_done); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (out_data !== '0 || out_tag !== '0) begin
      errors++; $display("FAIL reset_out got data=%0d tag=%0d exp 0 0", out_data, out_tag);
    end
    checks++;
    if (overrun !== '0) begin errors++; $display("FAIL reset_overrun got %h exp 0", overrun); end
    rst_n = 1'b1;
    for (int e = 1; e <= 362; e++) begin
      tick();
      checks++;
      if (core_rst !== boot_mask(e)) begin
        errors++; $display("FAIL boot_core_rst edge %0d got %h exp %h", e, core_rst, boot_mask(e));
      end
      checks++;
      if (boot_done !== (e >= 361)) begin
        errors++; $display("FAIL boot_done edge %0d got %b exp %b", e, boot_done, (e >= 361));
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL boot_idle_valid edge %0d got %b exp 0", e, out_valid); end
    end
  endtask

  task automatic test_multi();
    int exp_tag[5];
    int exp_dat[5];
    exp_tag = '{3, 7, 20, 3, 7};
    exp_dat = '{100, -7, 2020, 33, 77};
    out_ready = 1'b1;
    set_core(3, OUT_CODE, 100); set_core(7, OUT_CODE, -7); set_core(20, OUT_CODE, 2020);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL multi_capture_valid got %b exp 0", out_valid); end
    set_core(3, '0, 100); set_core(7, '0, -7); set_core(20, '0, 2020);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_tag !== TAG_W'(exp_tag[k]) || out_data !== DATA_W'(exp_dat[k])) begin
        errors++;
        $display("FAIL multi_beat%0d got v=%b tag=%0d data=%0d exp v=1 tag=%0d data=%0d",
                 k, out_valid, out_tag, out_data, exp_tag[k], exp_dat[k]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL multi_drain_valid got %b exp 0", out_valid); end
    set_core(3, OUT_CODE, 33); set_core(7, OUT_CODE, 77);
    tick();
    set_core(3, '0, 33); set_core(7, '0, 77);
    for (int k = 3; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_tag !== TAG_W'(exp_tag[k]) || out_data !== DATA_W'(exp_dat[k])) begin
        errors++;
        $display("FAIL multi_beat%0d got v=%b tag=%0d data=%0d exp v=1 tag=%0d data=%0d",
                 k, out_valid, out_tag, out_data, exp_tag[k], exp_dat[k]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL multi_drain2_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_core(5, OUT_CODE, -1234);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency got v=%b exp 0", out_valid); end
    set_core(5, '0, -1234);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== TAG_W'(5) || out_data !== DATA_W'(-1234)) begin
      errors++; $display("FAIL single_out got v=%b tag=%0d data=%0d exp v=1 tag=5 data=-1234", out_valid, out_tag, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got v=%b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [N_CORES-1:0] exp_ovr;
    exp_ovr = '0;
    exp_ovr[2] = 1'b1;
    out_ready = 1'b1;
    set_core(2, OUT_CODE, 55);
    tick();
    set_core(2, '0, 55);
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== TAG_W'(2) || out_data !== DATA_W'(55)) begin
      errors++; $display("FAIL bp_first got v=%b tag=%0d data=%0d exp v=1 tag=2 data=55", out_valid, out_tag, out_data);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 2) set_core(2, OUT_CODE, 77);
      if (k == 3) set_core(2, '0, 77);
      if (k == 5) set_core(2, OUT_CODE, 99);
      if (k == 6) set_core(2, '0, 99);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_tag !== TAG_W'(2) || out_data !== DATA_W'(55)) begin
        errors++; $display("FAIL bp_stable cycle %0d got v=%b tag=%0d data=%0d exp v=1 tag=2 data=55", k, out_valid, out_tag, out_data);
      end
    end
    checks++;
    if (overrun !== exp_ovr) begin errors++; $display("FAIL bp_overrun got %h exp %h", overrun, exp_ovr); end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== TAG_W'(2) || out_data !== DATA_W'(99)) begin
      errors++; $display("FAIL bp_release got v=%b tag=%0d data=%0d exp v=1 tag=2 data=99", out_valid, out_tag, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    for (int k = 10; k < 15; k++) set_core(k, OUT_CODE, k * 10);
    tick();
    for (int k = 10; k < 15; k++) set_core(k, '0, k * 10);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== TAG_W'(10) || out_data !== DATA_W'(100)) begin
      errors++; $display("FAIL mid_pre got v=%b tag=%0d data=%0d exp v=1 tag=10 data=100", out_valid, out_tag, out_data);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++;
    if (core_rst !== '1) begin errors++; $display("FAIL mid_core_rst got %h exp all ones", core_rst); end
    checks++;
    if (boot_done !== 1'b0 || overrun !== '0) begin
      errors++; $display("FAIL mid_flags got boot_done=%b overrun=%h exp 0 0", boot_done, overrun);
    end
    checks++;
    if (out_data !== '0 || out_tag !== '0) begin
      errors++; $display("FAIL mid_out got data=%0d tag=%0d exp 0 0", out_data, out_tag);
    end
    // core 9 raises its result code while still held in reset
    set_core(9, OUT_CODE, 909);
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 362; e++) begin
      tick();
      checks++;
      if (core_rst !== boot_mask(e)) begin
        errors++; $display("FAIL reboot_core_rst edge %0d got %h exp %h", e, core_rst, boot_mask(e));
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reboot_valid edge %0d got %b exp 0", e, out_valid); end
    end
    checks++;
    if (boot_done !== 1'b1 || overrun !== '0) begin
      errors++; $display("FAIL reboot_end got boot_done=%b overrun=%h exp 1 0", boot_done, overrun);
    end
  endtask

  task automatic test_mask();
    set_core(9, '0, 909);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mask_fall got v=%b exp 0", out_valid); end
    set_core(9, OUT_CODE, -909);
    tick();
    set_core(9, '0, -909);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== TAG_W'(9) || out_data !== DATA_W'(-909)) begin
      errors++; $display("FAIL mask_capture got v=%b tag=%0d data=%0d exp v=1 tag=9 data=-909", out_valid, out_tag, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mask_drain got v=%b exp 0", out_valid); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    core_en   = '0;
    core_data = '0;
    #12;
    test_reset();
    test_multi();
    test_single();
    test_backpressure();
    test_midreset();
    test_mask();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
